mest_pro_seq_ctrl: RTL and testbench
====================================

// Module: mest_pro_seq_ctrl
// PURPOSE
//  Central sequencer for the MESTPro core. Generates the one-hot idle/fetch/exec phase strobes that drive
//  mest_pro_fetch and the execute datapath. Handshakes with program memory (req/ack, variable wait states)
//  and stalls on multi-cycle execute. Detects HALT, fetch timeout and external abort.
//  Sits between the core top level (start/abort/status) and the fetch/exec stages.
// PARAMETERS
//  OP_CODE_SIZE      `OPCODE_SIZE        width of opcode field, taken from decode_reg MSBs
//  INSTRUCTION_SIZE  `INSTRUCTION_SIZE   instruction word width
//  FETCH_TIMEOUT     16                  max wait cycles for i_mem_ack before error; legal range 1..255
//  CNT_WIDTH         32                  width of retired-instruction counter
// PORTS
//  clk             in   1                  clock, rising edge
//  i_reset_n       in   1                  asynchronous, active-low reset
//  i_start         in   1                  start program from address 0; honoured in IDLE, HALTED, ERROR only
//  i_abort         in   1                  force return to IDLE from any state
//  i_mem_ack       in   1                  program memory data valid for the current o_mem_req
//  i_exec_busy     in   1                  execute datapath needs another cycle
//  i_opcode        in   OP_CODE_SIZE       opcode of decode_reg, valid in DECODE
//  o_idle_state    out  1                  to fetch: clears PC and decode_reg
//  o_fetch_state   out  1                  to fetch: latch instruction and increment PC
//  o_exec_state    out  1                  to fetch/exec: execute, jump/return qualifier
//  o_mem_req       out  1                  program memory read request
//  o_busy          out  1                  state not in {IDLE, HALTED, ERROR}
//  o_halted        out  1                  HALT retired
//  o_error         out  1                  fetch timeout occurred; sticky
//  o_instr_count   out  CNT_WIDTH          retired instructions since last start
// BEHAVIOUR
//  - States: IDLE, REQ, DECODE, EXEC, HALTED, ERROR. Reset -> IDLE. All outputs are 0 at reset except o_idle_state=1.
//  - IDLE: o_idle_state=1. On i_start -> REQ and clear o_instr_count.
//  - REQ: o_mem_req=1.
//      o_fetch_state = i_mem_ack. This is the only Mealy output.
//      On ack -> DECODE. Otherwise increment the wait counter.
//      If the counter reaches FETCH_TIMEOUT without ack -> ERROR.
//      Ack in the same cycle the limit is reached: ack wins.
//  - DECODE: one cycle. If i_opcode==`OPCODE_HALT -> HALTED and o_instr_count+1. Otherwise -> EXEC.
//  - EXEC: o_exec_state=1 every EXEC cycle.
//      If i_exec_busy, stay in EXEC.
//      Otherwise o_instr_count+1 and -> REQ. Back-to-back fetch, no bubble.
//  - HALTED: o_halted=1. ERROR: o_error=1.
//      In both, i_start -> REQ and clears halted/error/count.
//  - i_abort has highest priority in every state. Next state = IDLE; count is held.
//    i_abort together with i_start in IDLE -> stays IDLE.
//  - i_start in REQ/DECODE/EXEC is ignored.
//  - o_idle_state, o_exec_state, o_busy, o_halted, o_error and o_mem_req are decoded directly from registered state.
//  - o_instr_count saturates at all-ones and never wraps.
//  - Wait counter is $clog2(FETCH_TIMEOUT+1) bits. It clears on entry to REQ and on ack.
//  - Exactly one of idle/fetch/exec is high, or none (REQ without ack, DECODE, HALTED, ERROR).
//  - Asserting i_reset_n low mid-operation returns immediately to IDLE.
//    Fetch-stage PC/decode_reg clear via o_idle_state on the next cycle.
// STRUCTURE
//  - Package mest_pro_pkg: seq_state_t enum, OPCODE_HALT constant (mirrors `OPCODE_HALT in param.vh),
//    default FETCH_TIMEOUT.
//  - Sub-module mest_pro_timeout_cnt: clear/enable/limit inputs, expired output. Reused for later bus watchdogs.
//  - The state register uses asynchronous reset. All other logic is combinational next-state and output decode.
// TESTING
//  1. Reset, then i_start with ack asserted every REQ cycle, opcodes NOP,NOP,HALT.
//     -> fetch_state pulses 3x, exec_state 2x, o_halted=1, o_instr_count=3.
//  2. Ack delayed 5 cycles, FETCH_TIMEOUT=16.
//     -> o_mem_req high 6 cycles, o_fetch_state only in the ack cycle, no error.
//  3. No ack for 16 cycles -> o_error=1 on cycle 17, o_busy=0.
//     Then i_start -> REQ, o_error=0, o_instr_count=0.
//  4. i_exec_busy high for 3 cycles on an instruction -> o_exec_state high 4 cycles.
//     Count increments once, at the last cycle.
//  5. i_abort during EXEC -> IDLE next cycle, o_idle_state=1, count held.
//     i_abort+i_start together in IDLE -> remains IDLE.
//  6. Count preset near all-ones (CNT_WIDTH=4), run 20 NOPs -> o_instr_count stops at 4'hF.

Source files
------------

// File: rtl/mest_pro_pkg.sv
// Shared types and constants for the MESTPro core: sequencer states, opcode
// geometry and the HALT encoding mirrored from the core parameter header.
package mest_pro_pkg;

    localparam int unsigned OPCODE_SIZE           = 4;
    localparam int unsigned INSTRUCTION_SIZE      = 16;
    localparam int unsigned OPCODE_HALT           = 4'hF;
    localparam int unsigned DEFAULT_FETCH_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DECODE,
        ST_EXEC,
        ST_HALTED,
        ST_ERROR
    } seq_state_t;

endpackage

// File: rtl/mest_pro_timeout_cnt.sv
// Wait-cycle watchdog: counts enabled cycles and flags the cycle in which the
// count would reach the limit. Also intended for future bus watchdogs.
module mest_pro_timeout_cnt #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Fires on the enabled cycle that would bring the count up to the limit,
    // so a limit of N trips on the Nth consecutive enabled cycle.
    assign expired = enable && (cnt == limit - W'(1));

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/mest_pro_seq_ctrl.sv
// MESTPro central sequencer: idle/fetch/exec phase strobes, program memory
// handshake with timeout, multi-cycle execute stall, HALT and abort handling.
module mest_pro_seq_ctrl
    import mest_pro_pkg::*;
#(
    parameter int unsigned OP_CODE_SIZE     = OPCODE_SIZE,
    parameter int unsigned INSTRUCTION_SIZE = mest_pro_pkg::INSTRUCTION_SIZE,
    parameter int unsigned FETCH_TIMEOUT    = DEFAULT_FETCH_TIMEOUT,
    parameter int unsigned CNT_WIDTH        = 32
) (
    input  logic                    clk,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic                    i_mem_ack,
    input  logic                    i_exec_busy,
    input  logic [OP_CODE_SIZE-1:0] i_opcode,
    output logic                    o_idle_state,
    output logic                    o_fetch_state,
    output logic                    o_exec_state,
    output logic                    o_mem_req,
    output logic                    o_busy,
    output logic                    o_halted,
    output logic                    o_error,
    output logic [CNT_WIDTH-1:0]    o_instr_count
);

    localparam int unsigned TW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [OP_CODE_SIZE-1:0] HALT_OP = OP_CODE_SIZE'(OPCODE_HALT);

    generate
        if (OP_CODE_SIZE > INSTRUCTION_SIZE) begin : g_bad_opcode_size
            $error("OP_CODE_SIZE must not exceed INSTRUCTION_SIZE");
        end
        if (FETCH_TIMEOUT < 1 || FETCH_TIMEOUT > 255) begin : g_bad_timeout
            $error("FETCH_TIMEOUT must be in 1..255");
        end
    endgenerate

    seq_state_t             state, state_nxt;
    logic [CNT_WIDTH-1:0]   count, count_nxt, count_inc;
    logic                   wait_expired;

    // Counter is cleared whenever we are outside REQ, which covers every
    // entry into REQ, and also on the ack that ends a fetch.
    mest_pro_timeout_cnt #(.W(TW)) u_fetch_wd (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .clear     ((state != ST_REQ) || i_mem_ack),
        .enable    ((state == ST_REQ) && !i_mem_ack),
        .limit     (TW'(FETCH_TIMEOUT)),
        .expired   (wait_expired)
    );

    assign count_inc = (&count) ? count : count + CNT_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (i_abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED, ST_ERROR: begin
                    if (i_start) begin
                        state_nxt = ST_REQ;
                        count_nxt = '0;
                    end
                end
                ST_REQ: begin
                    if (i_mem_ack)
                        state_nxt = ST_DECODE;
                    else if (wait_expired)
                        state_nxt = ST_ERROR;
                end
                ST_DECODE: begin
                    if (i_opcode == HALT_OP) begin
                        state_nxt = ST_HALTED;
                        count_nxt = count_inc;
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!i_exec_busy) begin
                        state_nxt = ST_REQ;
                        count_nxt = count_inc;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    assign o_idle_state  = (state == ST_IDLE);
    assign o_fetch_state = (state == ST_REQ) && i_mem_ack;
    assign o_exec_state  = (state == ST_EXEC);
    assign o_mem_req     = (state == ST_REQ);
    assign o_busy        = (state == ST_REQ) || (state == ST_DECODE) || (state == ST_EXEC);
    assign o_halted      = (state == ST_HALTED);
    assign o_error       = (state == ST_ERROR);
    assign o_instr_count = count;

endmodule

// File: tb/tb_mest_pro_seq_ctrl.sv
// Bench for mest_pro_seq_ctrl: directed vector table, then randomized traffic
// compared cycle by cycle against a behavioural model of the sequencer.
module tb_mest_pro_seq_ctrl;
    import mest_pro_pkg::*;

    localparam int unsigned TO  = 16;
    localparam int unsigned CW  = 4;
    localparam int unsigned OPW = OPCODE_SIZE;

    localparam logic [6:0] E_IDLE = 7'b1000000;
    localparam logic [6:0] E_RQ   = 7'b0001100;
    localparam logic [6:0] E_RQA  = 7'b0101100;
    localparam logic [6:0] E_DEC  = 7'b0000100;
    localparam logic [6:0] E_EXE  = 7'b0010100;
    localparam logic [6:0] E_HLT  = 7'b0000010;
    localparam logic [6:0] E_ERR  = 7'b0000001;
    localparam logic [OPW-1:0] NOP  = '0;
    localparam logic [OPW-1:0] HALT = OPW'(OPCODE_HALT);

    logic clk, reset_n, start, abort, ack, ebusy;
    logic [OPW-1:0] opcode;
    logic idle_s, fetch_s, exec_s, mem_req, busy, halted, error;
    logic [CW-1:0] count;

    mest_pro_seq_ctrl #(
        .OP_CODE_SIZE(OPW), .INSTRUCTION_SIZE(INSTRUCTION_SIZE),
        .FETCH_TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .i_reset_n(reset_n), .i_start(start), .i_abort(abort),
        .i_mem_ack(ack), .i_exec_busy(ebusy), .i_opcode(opcode),
        .o_idle_state(idle_s), .o_fetch_state(fetch_s), .o_exec_state(exec_s),
        .o_mem_req(mem_req), .o_busy(busy), .o_halted(halted), .o_error(error),
        .o_instr_count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           s, a, k, b;
        logic [OPW-1:0] op;
        logic [6:0]     eo;
        logic [CW-1:0]  ec;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    wire [6:0] obs = {idle_s, fetch_s, exec_s, mem_req, busy, halted, error};

    task automatic add(input logic s, a, k, b, input logic [OPW-1:0] op,
                       input logic [6:0] eo, input int ec);
        vec_t v;
        v.s = s; v.a = a; v.k = k; v.b = b; v.op = op; v.eo = eo; v.ec = CW'(ec);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, a, k, b, input logic [OPW-1:0] op);
        start = s; abort = a; ack = k; ebusy = b; opcode = op;
    endtask

    // Behavioural model: where the program is, how long it has waited on
    // memory, and how many instructions have retired (saturating).
    int m_ph, m_wait, m_cnt;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_HALT = 4, P_ERR = 5;
    localparam int CMAX = (1 << CW) - 1;

    function automatic logic [6:0] model_out(input logic k);
        case (m_ph)
            P_IDLE:  return E_IDLE;
            P_FETCH: return k ? E_RQA : E_RQ;
            P_DEC:   return E_DEC;
            P_EXEC:  return E_EXE;
            P_HALT:  return E_HLT;
            default: return E_ERR;
        endcase
    endfunction

    task automatic model_step(input logic s, a, k, b, input logic [OPW-1:0] op);
        if (a) begin
            m_ph = P_IDLE;
        end else if (m_ph == P_IDLE || m_ph == P_HALT || m_ph == P_ERR) begin
            if (s) begin m_ph = P_FETCH; m_cnt = 0; m_wait = 0; end
        end else if (m_ph == P_FETCH) begin
            if (k) begin m_ph = P_DEC; m_wait = 0; end
            else begin
                m_wait++;
                if (m_wait >= TO) m_ph = P_ERR;
            end
        end else if (m_ph == P_DEC) begin
            if (op == HALT) begin m_ph = P_HALT; m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX; end
            else m_ph = P_EXEC;
        end else if (!b) begin
            m_ph = P_FETCH; m_wait = 0;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
    endtask

    initial begin
        int ack_pct;
        logic s, a, k, b;
        logic [OPW-1:0] op;

        // Nominal program NOP, NOP, HALT with immediate acks
        add(1,0,0,0,NOP, E_IDLE,0);
        add(0,0,1,0,NOP, E_RQA,0);  add(0,0,0,0,NOP, E_DEC,0);  add(0,0,0,0,NOP, E_EXE,0);
        add(0,0,1,0,NOP, E_RQA,1);  add(0,0,0,0,NOP, E_DEC,1);  add(0,0,0,0,NOP, E_EXE,1);
        add(0,0,1,0,NOP, E_RQA,2);  add(0,0,0,0,HALT,E_DEC,2);  add(0,0,0,0,NOP, E_HLT,3);
        // Restart from HALTED, ack after 5 wait cycles, 3-cycle execute stall
        add(1,0,0,0,NOP, E_HLT,3);
        for (int i = 0; i < 5; i++) add(0,0,0,0,NOP, E_RQ,0);
        add(0,0,1,0,NOP, E_RQA,0);  add(0,0,0,0,NOP, E_DEC,0);
        for (int i = 0; i < 3; i++) add(0,0,0,1,NOP, E_EXE,0);
        add(0,0,0,0,NOP, E_EXE,0);
        // Fetch timeout after exactly TO unacknowledged cycles, then restart
        for (int i = 0; i < int'(TO); i++) add(0,0,0,0,NOP, E_RQ,1);
        add(0,0,0,0,NOP, E_ERR,1);  add(1,0,0,0,NOP, E_ERR,1);
        // Start ignored while running; abort in EXEC holds count
        add(1,0,1,0,NOP, E_RQA,0);  add(1,0,0,0,NOP, E_DEC,0);  add(0,0,0,0,NOP, E_EXE,0);
        add(0,0,1,0,NOP, E_RQA,1);  add(0,0,0,0,NOP, E_DEC,1);  add(0,1,0,0,NOP, E_EXE,1);
        add(1,1,0,0,NOP, E_IDLE,1); add(0,0,0,0,NOP, E_IDLE,1);
        // Ack on the last allowed wait cycle wins over the timeout
        add(1,0,0,0,NOP, E_IDLE,1);
        for (int i = 0; i < int'(TO) - 1; i++) add(0,0,0,0,NOP, E_RQ,0);
        add(0,0,1,0,NOP, E_RQA,0);  add(0,0,0,0,HALT,E_DEC,0);  add(0,0,0,0,NOP, E_HLT,1);
        // 20 NOPs saturate the 4-bit retired counter
        add(1,0,0,0,NOP, E_HLT,1);
        for (int i = 0; i < 20; i++) begin
            add(0,0,1,0,NOP, E_RQA, (i < CMAX) ? i : CMAX);
            add(0,0,0,0,NOP, E_DEC, (i < CMAX) ? i : CMAX);
            add(0,0,0,0,NOP, E_EXE, (i < CMAX) ? i : CMAX);
        end
        add(0,0,1,0,NOP, E_RQA, CMAX);

        reset_n = 1'b0;
        drive(0,0,0,0,NOP);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {25'b0, obs}, {25'b0, E_IDLE});
        check("reset_count", {28'b0, count}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].s, tbl[i].a, tbl[i].k, tbl[i].b, tbl[i].op);
            @(negedge clk);
            check($sformatf("vec%0d_outputs", i), {25'b0, obs}, {25'b0, tbl[i].eo});
            check($sformatf("vec%0d_count", i), {28'b0, count}, {28'b0, tbl[i].ec});
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-run brings the model and DUT back to IDLE
        reset_n = 1'b0; #1;
        check("async_reset_outputs", {25'b0, obs}, {25'b0, E_IDLE});
        check("async_reset_count", {28'b0, count}, 32'd0);
        m_ph = P_IDLE; m_wait = 0; m_cnt = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        ack_pct = 100;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: ack_pct = 100;
                    1: ack_pct = 50;
                    2: ack_pct = 20;
                    default: ack_pct = 3;
                endcase
            end
            if (cyc % 700 == 350) begin
                reset_n = 1'b0; #1;
                check("rand_async_reset", {25'b0, obs, count}, {25'b0, E_IDLE, 4'd0});
                m_ph = P_IDLE; m_wait = 0; m_cnt = 0;
                @(posedge clk); #1;
                reset_n = 1'b1;
            end
            s  = ($urandom_range(0, 7) == 0);
            a  = ($urandom_range(0, 63) == 0);
            k  = ($urandom_range(1, 100) <= ack_pct);
            b  = ($urandom_range(0, 1) == 0);
            op = ($urandom_range(0, 5) == 0) ? HALT : OPW'($urandom_range(0, 14));
            drive(s, a, k, b, op);
            @(negedge clk);
            check($sformatf("rand%0d_outputs", cyc), {25'b0, obs}, {25'b0, model_out(k)});
            check($sformatf("rand%0d_count", cyc), {28'b0, count}, 32'(m_cnt));
            model_step(s, a, k, b, op);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
